// File: rtl/fdd_port_ctrl.sv
// Purpose : CPU-side floppy port between the FFF0h-FFF3h bus decode and the wd1793: side/drive latch,
//           CPU hold-until-DRQ with watchdog, retriggerable motor timer, status read.
// Latency : register writes and hold entry/exit take effect 1 clk_sys after the edge; dout/fdd_ready are combinational.
// Backpressure: none on the bus side; the CPU is stalled via cpu_hold until DRQ, BUSY drop, or watchdog expiry.
//
// Ports:
//   clk_sys, reset_n (sync, active-low), ce (CPU-rate tick for the timers)
//   sel, wr_n, rd, addr[1:0], din[7:0] -> CPU bus; dout[7:0] -> status read data
//   fdd_drq, fdd_busy, img_ready[DRIVES-1:0] -> from controller / image mounts
//   cpu_hold, fdd_side, fdd_drive[DW-1:0], fdd_ready, motor_on, hold_to -> control/status outputs
module fdd_port_ctrl #(
    parameter int DRIVES       = 2,
    parameter int DW           = 2,
    parameter int HOLD_TIMEOUT = 65535,
    parameter int MOTOR_TICKS  = 4000000
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              sel,
    input  logic              wr_n,
    input  logic              rd,
    input  logic [1:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    input  logic              fdd_drq,
    input  logic              fdd_busy,
    input  logic [DRIVES-1:0] img_ready,
    output logic              cpu_hold,
    output logic              fdd_side,
    output logic [DW-1:0]     fdd_drive,
    output logic              fdd_ready,
    output logic              motor_on,
    output logic              hold_to
);

    // Counters are sized to just hold their limit; a zero limit still needs one bit.
    localparam int HW = (HOLD_TIMEOUT > 0) ? $clog2(HOLD_TIMEOUT + 1) : 1;
    localparam int MW = (MOTOR_TICKS > 0) ? $clog2(MOTOR_TICKS + 1) : 1;
    localparam int IW = 1 << DW;

    localparam logic [HW-1:0] HOLD_LIM   = HW'(HOLD_TIMEOUT);
    localparam logic [MW-1:0] MOTOR_LOAD = MW'(MOTOR_TICKS);
    localparam logic [DW:0]   DRV_LIM    = (DW + 1)'(DRIVES);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [HW-1:0] wd_q, wd_d;
    logic          to_set;
    logic [MW-1:0] motor_cnt, motor_d;
    logic          we, we_q, we_edge;
    logic [IW-1:0] img_pad;
    logic          unused_din;

    // Only the first cycle of a write strobe acts, however long the CPU holds it.
    assign we      = sel & ~wr_n;
    assign we_edge = we & ~we_q;

    // Padding to a full power-of-two lets the drive number index it directly.
    assign img_pad   = IW'(img_ready);
    assign fdd_ready = img_pad[fdd_drive];
    assign cpu_hold  = (state_q == ST_HOLD);

    assign dout = {hold_to, motor_on, cpu_hold, fdd_ready, fdd_side, 1'b0, 2'(fdd_drive)};

    // Only some din bits matter depending on the register written.
    assign unused_din = &{1'b0, din};

    // Hold FSM: release by the controller always beats the watchdog.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        to_set  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (we_edge && (addr == 2'd0) && fdd_busy && !fdd_drq) begin
                    state_d = ST_HOLD;
                    wd_d    = '0;
                end
            end
            ST_HOLD: begin
                if (fdd_drq || !fdd_busy) begin
                    state_d = ST_IDLE;
                end else if ((HOLD_TIMEOUT != 0) && (wd_q >= HOLD_LIM)) begin
                    state_d = ST_IDLE;
                    to_set  = 1'b1;
                end else if (ce && (wd_q < HOLD_LIM)) begin
                    wd_d = wd_q + HW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Motor timer: any bus access retriggers, otherwise count ce ticks down to zero.
    always_comb begin
        motor_d = motor_cnt;
        if (we_edge || (rd && sel)) begin
            motor_d = MOTOR_LOAD;
        end else if (ce && (motor_cnt != '0)) begin
            motor_d = motor_cnt - MW'(1);
        end
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            wd_q      <= '0;
            we_q      <= 1'b0;
            hold_to   <= 1'b0;
            fdd_side  <= 1'b0;
            fdd_drive <= '0;
            motor_cnt <= '0;
            motor_on  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wd_q      <= wd_d;
            we_q      <= we;
            motor_cnt <= motor_d;
            motor_on  <= (motor_d != '0);

            // A fresh timeout wins over a clear landing on the same edge.
            if (to_set) begin
                hold_to <= 1'b1;
            end else if (we_edge && (addr == 2'd1) && din[7]) begin
                hold_to <= 1'b0;
            end

            if (we_edge && (addr == 2'd2)) begin
                fdd_side <= din[0];
            end

            // Out-of-range drive numbers are dropped so fdd_drive always names a real drive.
            if (we_edge && (addr == 2'd3) && ({1'b0, din[DW-1:0]} < DRV_LIM)) begin
                fdd_drive <= din[DW-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fdd_port_ctrl.sv
module tb_fdd_port_ctrl;

    localparam int DRIVES = 2;
    localparam int DW     = 2;
    localparam int HT     = 8;
    localparam int MT     = 5;

    logic              clk_sys = 1'b0;
    logic              reset_n = 1'b0;
    logic              ce = 1'b0;
    logic              sel = 1'b0;
    logic              wr_n = 1'b1;
    logic              rd = 1'b0;
    logic [1:0]        addr = '0;
    logic [7:0]        din = '0;
    logic [7:0]        dout;
    logic              fdd_drq = 1'b0;
    logic              fdd_busy = 1'b0;
    logic [DRIVES-1:0] img_ready = '1;
    logic              cpu_hold;
    logic              fdd_side;
    logic [DW-1:0]     fdd_drive;
    logic              fdd_ready;
    logic              motor_on;
    logic              hold_to;

    fdd_port_ctrl #(
        .DRIVES(DRIVES), .DW(DW), .HOLD_TIMEOUT(HT), .MOTOR_TICKS(MT)
    ) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce(ce), .sel(sel), .wr_n(wr_n), .rd(rd),
        .addr(addr), .din(din), .dout(dout), .fdd_drq(fdd_drq), .fdd_busy(fdd_busy),
        .img_ready(img_ready), .cpu_hold(cpu_hold), .fdd_side(fdd_side), .fdd_drive(fdd_drive),
        .fdd_ready(fdd_ready), .motor_on(motor_on), .hold_to(hold_to)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        int         cyc;
        logic [14:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ce_div = 1;

    // Staged stimulus, applied by step().
    logic              s_rst_n = 1'b0;
    logic              s_sel = 1'b0, s_wr_n = 1'b1, s_rd = 1'b0, s_drq = 1'b0, s_busy = 1'b0;
    logic [1:0]        s_addr = '0;
    logic [7:0]        s_din = '0;
    logic [DRIVES-1:0] s_img = '1;

    // Behavioural reference state.
    bit m_valid = 0;
    bit m_hold, m_to, m_side, m_prev_we;
    int m_drive, m_wd, m_motor;

    task automatic step();
        bit   ce_v, we_v, wedge, rel, tmo;
        int   d;
        exp_t e;
        @(posedge clk_sys);
        #1;
        cyc++;
        ce_v = ((cyc % ce_div) == 0);
        reset_n = s_rst_n; ce = ce_v; sel = s_sel; wr_n = s_wr_n; rd = s_rd;
        addr = s_addr; din = s_din; fdd_drq = s_drq; fdd_busy = s_busy; img_ready = s_img;
        if (m_valid) begin
            e.cyc = cyc;
            e.v   = {m_hold, m_side, 2'(m_drive), s_img[m_drive], (m_motor > 0), m_to,
                     m_to, (m_motor > 0), m_hold, s_img[m_drive], m_side, 1'b0, 2'(m_drive)};
            exp_q.push_back(e);
        end
        if (!s_rst_n) begin
            m_hold = 0; m_to = 0; m_side = 0; m_prev_we = 0;
            m_drive = 0; m_wd = 0; m_motor = 0; m_valid = 1;
        end else begin
            we_v      = s_sel && !s_wr_n;
            wedge     = we_v && !m_prev_we;
            m_prev_we = we_v;
            if (wedge || (s_rd && s_sel)) m_motor = MT;
            else if (ce_v && m_motor > 0) m_motor = m_motor - 1;
            tmo = 0;
            if (!m_hold) begin
                if (wedge && s_addr == 0 && s_busy && !s_drq) begin
                    m_hold = 1;
                    m_wd   = 0;
                end
            end else begin
                rel = s_drq || !s_busy;
                if (rel) m_hold = 0;
                else if (m_wd >= HT) begin m_hold = 0; tmo = 1; end
                else if (ce_v) m_wd = m_wd + 1;
            end
            if (wedge) begin
                if (s_addr == 1 && s_din[7]) m_to = 0;
                if (s_addr == 2) m_side = s_din[0];
                d = s_din % 4;
                if (s_addr == 3 && d < DRIVES) m_drive = d;
            end
            if (tmo) m_to = 1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d, input int low_cycles);
        s_sel = 1; s_wr_n = 0; s_addr = a; s_din = d;
        repeat (low_cycles) step();
        s_wr_n = 1; s_sel = 0;
        step();
    endtask

    // Monitor: compare every cycle the stimulus side has queued an expectation.
    initial begin
        exp_t e;
        logic [14:0] act;
        forever begin
            @(negedge clk_sys);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                act = {cpu_hold, fdd_side, 2'(fdd_drive), fdd_ready, motor_on, hold_to, dout};
                checks++;
                if (act !== e.v) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d got hold=%b side=%b drv=%0d rdy=%b mot=%b to=%b dout=%h want hold=%b side=%b drv=%0d rdy=%b mot=%b to=%b dout=%h",
                             e.cyc, act[14], act[13], act[12:11], act[10], act[9], act[8], act[7:0],
                             e.v[14], e.v[13], e.v[12:11], e.v[10], e.v[9], e.v[8], e.v[7:0]);
                end
            end
        end
    end

    initial begin
        #1ms;
        errors++;
        $display("FAIL global_timeout cyc=%0d", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit");
    end

    initial begin
        // Reset with both images mounted.
        ce_div = 4;
        s_rst_n = 0; s_img = 2'b11;
        repeat (2) step();
        s_rst_n = 1;
        repeat (2) step();

        // Drive/side: second drive write is out of range and ignored.
        wr(2'd3, 8'd1, 1);
        wr(2'd3, 8'd3, 1);
        wr(2'd2, 8'd1, 1);
        s_img = 2'b01; repeat (3) step();
        s_img = 2'b10; repeat (3) step();
        s_img = 2'b11;
        // Long strobe: one action only.
        wr(2'd2, 8'd0, 5);
        wr(2'd3, 8'd0, 3);

        // Hold then DRQ well before the watchdog (8 ticks * 20 cycles).
        ce_div = 20;
        s_busy = 1; s_drq = 0;
        wr(2'd0, 8'd0, 1);
        repeat (100) step();
        s_drq = 1; repeat (3) step();
        s_drq = 0; s_busy = 0; repeat (2) step();

        // Immediate release: controller not busy.
        wr(2'd0, 8'd0, 1);
        repeat (4) step();
        s_busy = 1; s_drq = 1;
        wr(2'd0, 8'd0, 1);
        s_drq = 0; s_busy = 0; repeat (2) step();

        // Watchdog expiry, clear, then release coinciding with expiry.
        ce_div = 1;
        s_busy = 1; s_drq = 0;
        wr(2'd0, 8'd0, 1);
        repeat (15) step();
        wr(2'd1, 8'h7F, 1);
        wr(2'd1, 8'h80, 1);
        wr(2'd0, 8'd0, 1);
        for (int i = 0; i < 50 && !(m_hold && m_wd == HT); i++) step();
        s_drq = 1; step();
        s_drq = 0; s_busy = 0; repeat (3) step();

        // Motor timer and retrigger by read.
        ce_div = 4;
        repeat (30) step();
        wr(2'd2, 8'd1, 1);
        repeat (10) step();
        s_sel = 1; s_rd = 1; step();
        s_sel = 0; s_rd = 0;
        repeat (30) step();

        // Reset in the middle of a hold.
        s_busy = 1; s_drq = 0;
        wr(2'd0, 8'd0, 1);
        repeat (3) step();
        s_rst_n = 0; step();
        s_rst_n = 1; repeat (3) step();
        s_busy = 0;

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            if (i % 100 == 0) ce_div = $urandom_range(1, 3);
            s_sel   = ($urandom_range(0, 3) != 0);
            s_wr_n  = ($urandom_range(0, 2) != 0);
            s_rd    = ($urandom_range(0, 15) == 0);
            s_addr  = 2'($urandom_range(0, 3));
            s_din   = 8'($urandom_range(0, 255));
            s_busy  = ($urandom_range(0, 7) != 0);
            s_drq   = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 31) == 0) s_img = 2'($urandom_range(0, 3));
            s_rst_n = ($urandom_range(0, 299) != 0);
            step();
        end
        s_rst_n = 1; s_sel = 0; s_wr_n = 1; s_rd = 0;
        repeat (2) step();

        repeat (2) @(negedge clk_sys);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fdd_port_ctrl.md
Name: fdd_port_ctrl

Overview:
- Parametrised successor to the single-drive floppy control port (side/drive latch plus CPU-hold-until-DRQ) in the Specialist MX top level.
- Sits between the CPU bus (decoded at FFF0h–FFF3h) and the wd1793 controller.
- Adds N-drive selection, per-drive image-ready gating, a CPU hold watchdog with a sticky timeout flag, a retriggerable motor timer and a readable status register.

Parameters:
- DRIVES, 2, number of drives, 1..4.
- DW, 2, drive-select width; must satisfy 2**DW >= DRIVES.
- HOLD_TIMEOUT, 65535, ce ticks before a pending hold is force-released; 0 disables the watchdog.
- MOTOR_TICKS, 4000000, ce ticks the motor stays on after the last port access.

Ports:
- clk_sys  in  1  system clock (96 MHz).
- reset_n  in  1  synchronous reset, active-low.
- ce  in  1  CPU clock-enable tick (2/4 MHz), used for the timers.
- sel  in  1  port-group select (FFF0h–FFF3h decode).
- wr_n  in  1  CPU write strobe, active-low.
- rd  in  1  CPU read strobe (DBIN).
- addr  in  2  register address.
- din  in  8  CPU write data.
- dout  out  8  status read data.
- fdd_drq  in  1  wd1793 DRQ.
- fdd_busy  in  1  wd1793 BUSY.
- img_ready  in  DRIVES  per-drive image mounted.
- cpu_hold  out  1  CPU HOLD request.
- fdd_side  out  1  side select to wd1793.
- fdd_drive  out  DW  selected drive.
- fdd_ready  out  1  READY to wd1793.
- motor_on  out  1  motor/activity indicator.
- hold_to  out  1  sticky hold-timeout flag.

Behaviour:

Reset (reset_n=0 at a clk_sys edge):
- cpu_hold=0, fdd_side=0, fdd_drive=0, motor_on=0, hold_to=0.
- Timers cleared; FSM to IDLE; write-edge detector cleared.
- Reset mid-HOLD releases cpu_hold on the next edge.

Write strobe:
- we = sel & ~wr_n.
- Action occurs on the first cycle of a rising edge of we only, one action per bus write.
- Holding we low→high→held high gives exactly one action.

Register writes:
- addr 0: hold request (see FSM).
- addr 1: if din[7]=1, clear hold_to. Other bits ignored.
- addr 2: fdd_side <= din[0].
- addr 3: if din[DW-1:0] < DRIVES then fdd_drive <= din[DW-1:0]; otherwise the write is ignored and the drive is unchanged.

Motor timer:
- Any write edge, or any read (rd & sel), reloads the counter to MOTOR_TICKS.
- Counter decrements on ce while nonzero.
- motor_on = (counter != 0), registered.

Readiness:
- fdd_ready = img_ready[fdd_drive], combinational.

Status read:
- dout = {hold_to, motor_on, cpu_hold, fdd_ready, fdd_side, 1'b0, fdd_drive zero-extended to 2 bits}, combinational, for any addr.
- Reads have no side effect other than the motor reload.

Hold FSM:
- IDLE:
  - Write edge to addr 0: if fdd_busy & ~fdd_drq, go to HOLD, set cpu_hold=1, clear the watchdog.
  - Otherwise stay in IDLE with cpu_hold=0. The release condition wins on the same cycle.
- HOLD, evaluated every clk_sys in priority order:
  - fdd_drq | ~fdd_busy: go to IDLE, cpu_hold=0 on the next edge.
  - Else, if HOLD_TIMEOUT != 0 and the watchdog has reached HOLD_TIMEOUT: go to IDLE, cpu_hold=0, hold_to=1.
  - Else, the watchdog increments on ce.
  - Additional addr 0 writes in HOLD are ignored; the CPU cannot issue them while held.
- Simultaneous release and timeout in the same cycle: release wins and hold_to is not set.
- Release latency: cpu_hold drops exactly 1 clk_sys after the release condition is seen.

Widths:
- Watchdog and motor counters are sized to $clog2(param+1) and saturate; no wrap-around.

Test Plan:
1. Reset: reset_n=0 for 2 cycles with img_ready=2'b11 -> all outputs 0, fdd_ready=1, dout=8'h10.
2. Drive/side: write addr3=1, then addr3=3 with DRIVES=2, then addr2=1 -> fdd_drive=1 (the second write is ignored), fdd_side=1, fdd_ready=img_ready[1], dout[3]=1.
3. Hold then DRQ: busy=1, drq=0, write addr0 -> cpu_hold=1 one edge after the write; raise drq 100 cycles later -> cpu_hold=0 on the next edge, hold_to=0.
4. Immediate release: busy=0 at the addr0 write -> cpu_hold never asserts.
5. Watchdog: HOLD_TIMEOUT=8, busy=1, drq=0, write addr0 -> cpu_hold=0 and hold_to=1 after 8 ce ticks; write addr1=8'h80 -> hold_to=0; release and timeout on the same cycle -> hold_to stays 0.
6. Motor: MOTOR_TICKS=5, single write -> motor_on=1 for 5 ce ticks then 0; a read at tick 3 extends it to 5 ticks past the read; reset_n=0 mid-HOLD -> cpu_hold=0 on the next edge.
